mem_proto_monitor: RTL and testbench

//  Passive, cycle-accurate protocol monitor for the valid/ready memory interface (addr, wdata, wr_rd, valid, rdata, ready).

---
 rtl/mem_mon_pkg.sv | 23 ++
 rtl/mem_mon_shadow.sv | 45 ++++
 rtl/mem_proto_monitor.sv | 179 +++++++++++++++++
 tb/tb_mem_proto_monitor.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_mon_pkg.sv
// Shared types and constants for the memory protocol monitor.
//   mon_state_e : request tracking FSM states
//   E_*         : bit indices into err_flags
//   sat_inc8    : saturating increment used for the 8-bit wait counter
package mem_mon_pkg;

    typedef enum logic [1:0] {IDLE, PEND, TOUT} mon_state_e;

    localparam int unsigned E_TOUT   = 0;
    localparam int unsigned E_DROP   = 1;
    localparam int unsigned E_STABLE = 2;
    localparam int unsigned E_SPUR   = 3;
    localparam int unsigned E_XADDR  = 4;
    localparam int unsigned E_XWDATA = 5;
    localparam int unsigned E_XRDATA = 6;
    localparam int unsigned E_DATA   = 7;
    localparam int unsigned NUM_ERR  = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_mon_shadow.sv
// Shadow memory for read-data checking.
// Ports:
//   clk, rst (sync, active-low) - clock / reset (clears the written bits)
//   wr_hs, rd_hs                - write / read handshake this cycle
//   addr, wdata, rdata          - monitored bus values at the handshake
//   mismatch                    - read of a previously written address returned other data
module mem_mon_shadow
    import mem_mon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_hs,
    input  logic                  rd_hs,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  mismatch
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            written_q <= '0;
        end else if (wr_hs) begin
            written_q[addr] <= 1'b1;
        end
    end

    // Data array needs no reset: entries are only trusted once their written bit is set.
    always_ff @(posedge clk) begin
        if (rst && wr_hs) begin
            mem_q[addr] <= wdata;
        end
    end

    assign mismatch = rd_hs && written_q[addr] && (mem_q[addr] != rdata);

endmodule

// File: rtl/mem_proto_monitor.sv
// Passive valid/ready memory interface protocol monitor.
// Checks bounded handshake wait, request stability, X on bus fields and spurious ready;
// keeps sticky error flags, saturating counters and the worst-case wait.
// Optional feature: define SHADOW_CHECK_EN to add shadow-memory read-data checking (E_DATA).
// Ports:
//   clk, rst (sync, active-low)          - clock / reset
//   addr, wdata, wr_rd, valid            - monitored request
//   rdata, ready                         - monitored response
//   clr                                  - clears err_flags, counters and max_lat
//   err_flags, err_pulse                 - sticky error bits / pulse on any new error
//   wr_cnt, rd_cnt, err_cnt, max_lat     - saturating statistics
module mem_proto_monitor
    import mem_mon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  wr_rd,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    input  logic                  clr,
    output logic [NUM_ERR-1:0]    err_flags,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [7:0]            max_lat
);

    localparam logic [7:0]           MAX_WAIT_L = 8'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    mon_state_e            state_q, state_d;
    logic [7:0]            lat_q, lat_d;
    logic                  stab_q, stab_d;
    logic                  latch;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wr_rd_q;

    logic                  hs;
    logic [7:0]            cur_wait;
    logic                  data_err;
    logic [NUM_ERR-1:0]    new_err;

    logic [NUM_ERR-1:0]    flags_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_d, rd_cnt_d, err_cnt_d;
    logic [7:0]            max_lat_d;

    assign hs       = valid && ready;
    assign cur_wait = (state_q == IDLE) ? 8'd0 : lat_q;

`ifdef SHADOW_CHECK_EN
    mem_mon_shadow #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .wr_hs    (hs && wr_rd),
        .rd_hs    (hs && !wr_rd),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .mismatch (data_err)
    );
`else
    assign data_err = 1'b0;
`endif

    // Request tracking FSM; lat_q counts edges valid has waited without ready.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        stab_d  = stab_q;
        latch   = 1'b0;
        new_err = '0;

        unique case (state_q)
            IDLE: begin
                if (valid && !ready) begin
                    state_d = PEND;
                    lat_d   = 8'd1;
                    stab_d  = 1'b0;
                    latch   = 1'b1;
                end
            end
            PEND: begin
                if (!valid) begin
                    state_d         = IDLE;
                    new_err[E_DROP] = 1'b1;
                end else if (ready) begin
                    state_d = IDLE;
                end else if (lat_q >= MAX_WAIT_L) begin
                    state_d         = TOUT;
                    lat_d           = sat_inc8(lat_q);
                    new_err[E_TOUT] = 1'b1;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            TOUT: begin
                if (!valid || ready) begin
                    state_d = IDLE;
                end else begin
                    lat_d = sat_inc8(lat_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // Reported once per request so a held bad value does not flood err_cnt.
        if (state_q != IDLE && valid && !stab_q &&
            (addr != addr_q || wr_rd != wr_rd_q || (wr_rd_q && wdata != wdata_q))) begin
            new_err[E_STABLE] = 1'b1;
            stab_d            = 1'b1;
        end

        new_err[E_SPUR]   = ready && !valid;
        new_err[E_XADDR]  = hs && $isunknown(addr);
        new_err[E_XWDATA] = hs && wr_rd && $isunknown(wdata);
        new_err[E_XRDATA] = hs && !wr_rd && $isunknown(rdata);
        new_err[E_DATA]   = data_err;
    end

    // Statistics: clear is applied first, then this cycle's events on top of it.
    always_comb begin
        flags_d   = (clr ? '0 : err_flags) | new_err;
        err_cnt_d = clr ? '0 : err_cnt;
        wr_cnt_d  = clr ? '0 : wr_cnt;
        rd_cnt_d  = clr ? '0 : rd_cnt;
        max_lat_d = clr ? 8'd0 : max_lat;

        if (|new_err && err_cnt_d != CNT_MAX) err_cnt_d = err_cnt_d + CNT_WIDTH'(1);
        if (hs && wr_rd && wr_cnt_d != CNT_MAX) wr_cnt_d = wr_cnt_d + CNT_WIDTH'(1);
        if (hs && !wr_rd && rd_cnt_d != CNT_MAX) rd_cnt_d = rd_cnt_d + CNT_WIDTH'(1);
        if (hs && cur_wait > max_lat_d) max_lat_d = cur_wait;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            lat_q     <= 8'd0;
            stab_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_rd_q   <= 1'b0;
            err_flags <= '0;
            err_pulse <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
            max_lat   <= 8'd0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            stab_q    <= stab_d;
            if (latch) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wr_rd_q <= wr_rd;
            end
            err_flags <= flags_d;
            err_pulse <= |new_err;
            wr_cnt    <= wr_cnt_d;
            rd_cnt    <= rd_cnt_d;
            err_cnt   <= err_cnt_d;
            max_lat   <= max_lat_d;
        end
    end

endmodule

// File: tb/tb_mem_proto_monitor.sv
module tb_mem_proto_monitor;

    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int MW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr_rd;
    logic          valid;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          clr;
    logic [7:0]    err_flags;
    logic          err_pulse;
    logic [CW-1:0] wr_cnt, rd_cnt, err_cnt;
    logic [7:0]    max_lat;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    bit chk_on  = 1'b0;

    mem_proto_monitor #(
        .ADDR_WIDTH (AW),
        .WIDTH      (DW),
        .MAX_WAIT   (MW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .wr_rd     (wr_rd),
        .valid     (valid),
        .rdata     (rdata),
        .ready     (ready),
        .clr       (clr),
        .err_flags (err_flags),
        .err_pulse (err_pulse),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt),
        .err_cnt   (err_cnt),
        .max_lat   (max_lat)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    // ---------------- transaction-level model ----------------
    int          wait_c;      // edges the current request has waited, 0 = no request open
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic        s_wr;
    bit          stab_done;
    logic [7:0]  e_flags;
    bit          e_pulse;
    int          e_wr, e_rd, e_err, e_lat;
    logic [DW-1:0] shadow [int];

    always @(posedge clk) begin
        logic [7:0] ev;
        bit hs;
        int lat;
        if (!rst) begin
            wait_c = 0; stab_done = 0; e_flags = 0; e_pulse = 0;
            e_wr = 0; e_rd = 0; e_err = 0; e_lat = 0;
            shadow.delete();
        end else begin
            ev  = 8'h00;
            hs  = valid && ready;
            lat = sat(wait_c, 255);
            if (valid && !ready && wait_c == MW) ev[0] = 1'b1;
            if (!valid && wait_c >= 1 && wait_c <= MW) ev[1] = 1'b1;
            if (valid && wait_c > 0 && !stab_done &&
                (addr != s_addr || wr_rd != s_wr || (s_wr && wdata != s_wdata))) begin
                ev[2] = 1'b1;
                stab_done = 1;
            end
            if (ready && !valid) ev[3] = 1'b1;
            if (hs && $isunknown(addr)) ev[4] = 1'b1;
            if (hs && wr_rd && $isunknown(wdata)) ev[5] = 1'b1;
            if (hs && !wr_rd && $isunknown(rdata)) ev[6] = 1'b1;
`ifdef SHADOW_CHECK_EN
            if (hs && !wr_rd && shadow.exists(int'(addr)) && shadow[int'(addr)] != rdata)
                ev[7] = 1'b1;
            if (hs && wr_rd) shadow[int'(addr)] = wdata;
`endif
            if (clr) begin
                e_flags = 0; e_wr = 0; e_rd = 0; e_err = 0; e_lat = 0;
            end
            e_flags = e_flags | ev;
            e_pulse = (ev != 0);
            if (ev != 0) e_err = sat(e_err + 1, CMAX);
            if (hs && wr_rd) e_wr = sat(e_wr + 1, CMAX);
            if (hs && !wr_rd) e_rd = sat(e_rd + 1, CMAX);
            if (hs && lat > e_lat) e_lat = lat;
            if (valid && !ready) begin
                if (wait_c == 0) begin
                    s_addr = addr; s_wr = wr_rd; s_wdata = wdata; stab_done = 0;
                end
                wait_c++;
            end else begin
                wait_c = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("err_flags", 32'(err_flags), 32'(e_flags));
            check("err_pulse", 32'(err_pulse), 32'(e_pulse));
            check("wr_cnt", 32'(wr_cnt), 32'(e_wr));
            check("rd_cnt", 32'(rd_cnt), 32'(e_rd));
            check("err_cnt", 32'(err_cnt), 32'(e_err));
            check("max_lat", 32'(max_lat), 32'(e_lat));
            if (err_pulse) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet();
        valid = 1'b0; ready = 1'b0; clr = 1'b0; wr_rd = 1'b0;
    endtask

    task automatic do_clr();
        quiet();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b0; addr = '0; wdata = '0; rdata = '0;
        quiet();
        cyc(2);
        chk_on = 1'b1;
        check("reset_flags", 32'(err_flags), 32'h0);
        check("reset_wr_cnt", 32'(wr_cnt), 32'h0);
        rst = 1'b1;
        cyc();

        // 1: write waiting one cycle
        valid = 1; wr_rd = 1; addr = 6'd5; wdata = 16'hA5A5;
        cyc();
        ready = 1;
        cyc();
        quiet();
        cyc();
        check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t1_max_lat", 32'(max_lat), 32'd1);
        check("t1_flags", 32'(err_flags), 32'h0);

        // wait of exactly MAX_WAIT is still legal
        do_clr();
        valid = 1; wr_rd = 0; addr = 6'd11;
        cyc(MW);
        ready = 1;
        cyc();
        quiet();
        cyc();
        check("edge_wait_flags", 32'(err_flags), 32'h0);
        check("edge_wait_lat", 32'(max_lat), 32'd8);

        // 2: timeout after 9 waiting edges
        do_clr();
        p0 = pulses;
        valid = 1; wr_rd = 0; addr = 6'd2;
        cyc(9);
        quiet();
        cyc(2);
        check("t2_flags", 32'(err_flags), 32'h01);
        check("t2_err_cnt", 32'(err_cnt), 32'd1);
        check("t2_pulses", 32'(pulses - p0), 32'd1);

        // 3: addr instability then drop
        do_clr();
        valid = 1; wr_rd = 0; addr = 6'd3;
        cyc();
        addr = 6'd4;
        cyc();
        valid = 0;
        cyc(2);
        check("t3_flags", 32'(err_flags), 32'h06);
        check("t3_err_cnt", 32'(err_cnt), 32'd2);

        // 4: spurious ready, X read data, clear colliding with new error
        do_clr();
        ready = 1;
        cyc();
        ready = 0;
        valid = 1; wr_rd = 0; addr = 6'd20; ready = 1; rdata = 'x;
        cyc();
        quiet();
        rdata = 16'h0;
        cyc();
        check("t4_spur", 32'(err_flags[3]), 32'd1);
        clr = 1; ready = 1;
        cyc();
        quiet();
        check("t4_clr_flags", 32'(err_flags), 32'h08);
        check("t4_clr_err_cnt", 32'(err_cnt), 32'd1);
        cyc();

`ifdef SHADOW_CHECK_EN
        // 5: shadow read-data check
        do_clr();
        valid = 1; ready = 1; wr_rd = 1; addr = 6'd7; wdata = 16'h1234;
        cyc();
        wr_rd = 0; rdata = 16'h1234;
        cyc();
        quiet();
        cyc();
        check("t5_match", 32'(err_flags), 32'h0);
        valid = 1; ready = 1; wr_rd = 0; addr = 6'd7; rdata = 16'h1235;
        cyc();
        quiet();
        cyc();
        check("t5_mismatch", 32'(err_flags[7]), 32'd1);
        do_clr();
        valid = 1; ready = 1; wr_rd = 0; addr = 6'd9; rdata = 16'hBEEF;
        cyc();
        quiet();
        cyc();
        check("t5_unwritten", 32'(err_flags), 32'h0);
`endif

        // 6: reset in the middle of a pending write
        do_clr();
        valid = 1; wr_rd = 1; addr = 6'd1; wdata = 16'h0F0F;
        cyc(2);
        rst = 0;
        cyc();
        check("t6_rst_flags", 32'(err_flags), 32'h0);
        check("t6_rst_err_cnt", 32'(err_cnt), 32'h0);
        rst = 1;
        cyc();
        ready = 1;
        cyc();
        quiet();
        cyc();
        check("t6_no_drop", 32'(err_flags), 32'h0);
        check("t6_wr_cnt", 32'(wr_cnt), 32'd1);

        // back-to-back writes saturate wr_cnt
        do_clr();
        valid = 1; ready = 1; wr_rd = 1; addr = 6'd30; wdata = 16'h5555;
        cyc(CMAX + 4);
        quiet();
        cyc();
        check("sat_wr_cnt", 32'(wr_cnt), 32'(CMAX));
        check("sat_wr_lat", 32'(max_lat), 32'd0);

        // back-to-back reads
        valid = 1; ready = 1; wr_rd = 0; addr = 6'd31; rdata = 16'h0;
        cyc(3);
        quiet();
        cyc();
        check("b2b_rd_cnt", 32'(rd_cnt), 32'd3);

        // err_cnt saturation
        do_clr();
        ready = 1;
        cyc(CMAX + 5);
        quiet();
        cyc();
        check("sat_err_cnt", 32'(err_cnt), 32'(CMAX));

        // max_lat saturation
        do_clr();
        valid = 1; wr_rd = 0; addr = 6'd12;
        cyc(260);
        ready = 1;
        cyc();
        quiet();
        cyc();
        check("sat_max_lat", 32'(max_lat), 32'd255);
        check("sat_lat_flags", 32'(err_flags), 32'h01);

        cyc(2);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
